sort4_alu: RTL
==============

# sort4_alu

Sequential sorter that reorders four N-bit unsigned values into ascending order with one compare-swap per clock. Each comparison goes through an instance of the team ALU in SUB mode (m = 3'd1), using its borrow flag `cf`. The block drives the ALU the same way as the ALU bench, but from hardware. It sits beside the ALU in the lab-1 datapath and presents sorted results to the board display and switch logic.

## Interface
- `N`, default 4: data width of each element and of the ALU instance.

- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request to load and sort; sampled only in IDLE or DONE.
- `x0`, `x1`, `x2`, `x3`  in  N each: unsorted operands, captured on the accepting edge.
- `s0`, `s1`, `s2`, `s3`  out  N each: working registers; hold the ascending result in DONE (s0 smallest).
- `busy`  out  1: high while a sort is in progress.
- `done`  out  1: high in DONE; stays high until the next accepted start.

## Operation
- One internal ALU, width N, with `m` tied to 3'd1 (SUB). Operands are muxed per state: `a` = r[i+1], `b` = r[i].
- The ALU SUB computes y = a − b with `cf` = borrow, i.e. `cf` = 1 iff a < b unsigned.
- Swap condition: swap r[i] and r[i+1] iff `cf` = 1, i.e. r[i+1] < r[i]. Equal values are never swapped, so the sort is stable.
- `of`, `zf` and `y` of the ALU are unused.
- FSM states and their compare pairs:
  - IDLE
  - C1 (0,1)
  - C2 (1,2)
  - C3 (2,3)
  - C4 (0,1)
  - C5 (1,2)
  - C6 (0,1)
  - DONE
- Transitions:
  - IDLE, or DONE, with start=1 → C1. On this edge, load r0..r3 ← x0..x3 and clear `done`.
  - C1 → C2 → C3 → C4 → C5 → C6 unconditionally, one edge each. On every edge, apply the compare-swap for that state's pair.
  - C6 → DONE. Apply the last compare-swap on this edge.
  - DONE with start=0 stays in DONE, holding outputs.
- `start` in states C1–C6 is ignored. There is no queuing and no restart.
- `busy` = 1 in C1–C6 and 0 in IDLE and DONE. `done` = 1 only in DONE.
- All outputs are registered; s0..s3 are driven directly from r0..r3.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, r0..r3=0, `s0`..`s3`=0, `busy`=0, `done`=0. This holds immediately and regardless of `clk`.
- Reset asserted mid-sort: the partial result is discarded and all values above apply. After release, a new start is required.
- Accept edge E0 (start=1 in IDLE or DONE): `busy`=1 and `done`=0 are visible after E0. The six compare edges follow as E1..E6.
- `done`=1 and `busy`=0 are visible after E6. Result latency is 6 cycles after the accept edge, 7 edges including it.
- Holding `start`=1 continuously restarts the sort every 7 cycles. `done` is high for exactly one cycle before each reload.
- The ALU is combinational. Compare and swap for a pair complete within one cycle; there is no extra pipeline stage.
- Any x change after E0 has no effect until the next accept.

## Test plan
- Reset: hold rst_n=0 with random x and start=1 → s0..s3=0, busy=0, done=0. Release, keep start=0 for 5 cycles → state stays IDLE, outputs unchanged.
- Reverse order: x=(4'hF, 4'hA, 4'h5, 4'h0), pulse start → busy=1 for 6 cycles, then done=1 with s=(0, 5, A, F).
- Duplicates and already sorted: x=(3, 3, 3, 3) → s=(3, 3, 3, 3). Then x=(1, 2, 8, 9) → s=(1, 2, 8, 9). Both have done latency of exactly 6 cycles after the accept edge.
- Unsigned boundary: x=(4'h8, 4'h7, 4'hC, 4'h1) → s=(1, 7, 8, C). This confirms cf-based unsigned compare, with 8 > 7 despite the sign bit.
- Busy protection: start x=(9, 2, 6, 4). At E3, assert start=1 with x=(0, 0, 0, 0) → ignored, result s=(2, 4, 6, 9). A start pulse in DONE with x=(5, 1, 1, 0) → reload, and 6 cycles later s=(0, 1, 1, 5).
- Mid-sort reset: pulse rst_n=0 between E3 and E4 → outputs 0 asynchronously, done never rises. After release, the next start sorts correctly.

Source files
------------

// File: rtl/sort4_alu.sv
// sort4_alu: sequential four-element ascending sorter.
//   Performs one compare-swap per clock over the fixed network
//   (0,1) (1,2) (2,3) (0,1) (1,2) (0,1). Every comparison is made by the
//   team ALU in SUB mode, and its borrow flag selects the swap.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            load x0..x3 and begin a sort (honoured in IDLE/DONE only)
//   x0..x3  [N-1:0]  unsorted operands, captured on the accepting edge
//   s0..s3  [N-1:0]  working registers; ascending result in DONE (s0 smallest)
//   busy             high while compare-swaps are in progress
//   done             high in DONE until the next accepted start
//
// alu: team ALU (combinational).
//   a, b [N-1:0]  operands        m [2:0]  operation select
//   y    [N-1:0]  result          cf       carry / borrow / shifted-out bit
//   of            signed overflow zf       result is zero

module alu #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   m,
  output logic [N-1:0] y,
  output logic         cf,
  output logic         of,
  output logic         zf
);

  logic [N:0] ext;

  always_comb begin
    ext = '0;
    y   = '0;
    cf  = 1'b0;
    of  = 1'b0;
    case (m)
      3'd0: begin
        ext = {1'b0, a} + {1'b0, b};
        y   = ext[N-1:0];
        cf  = ext[N];
        of  = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      3'd1: begin
        // The extra top bit of the widened difference is the borrow: set iff a < b.
        ext = {1'b0, a} - {1'b0, b};
        y   = ext[N-1:0];
        cf  = ext[N];
        of  = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]);
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = ~a;
      3'd6: begin
        y  = {a[N-2:0], 1'b0};
        cf = a[N-1];
      end
      default: begin
        y  = {1'b0, a[N-1:1]};
        cf = a[0];
      end
    endcase
    zf = (y == '0);
  end

endmodule

module sort4_alu #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x0,
  input  logic [N-1:0] x1,
  input  logic [N-1:0] x2,
  input  logic [N-1:0] x3,
  output logic [N-1:0] s0,
  output logic [N-1:0] s1,
  output logic [N-1:0] s2,
  output logic [N-1:0] s3,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_C1,
    S_C2,
    S_C3,
    S_C4,
    S_C5,
    S_C6,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] r_q [4];
  logic [N-1:0] r_d [4];
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [1:0]   idx_lo, idx_hi;
  logic [N-1:0] alu_a, alu_b, alu_y;
  logic         alu_cf, alu_of, alu_zf;
  logic         alu_unused;

  // Lower index of the pair compared in the current state.
  always_comb begin
    idx_lo = 2'd0;
    case (state_q)
      S_C2, S_C5: idx_lo = 2'd1;
      S_C3:       idx_lo = 2'd2;
      default:    idx_lo = 2'd0;
    endcase
    idx_hi = idx_lo + 2'd1;
    alu_a  = r_q[idx_hi];
    alu_b  = r_q[idx_lo];
  end

  alu #(.N(N)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .m  (3'd1),
    .y  (alu_y),
    .cf (alu_cf),
    .of (alu_of),
    .zf (alu_zf)
  );

  // Only the borrow flag takes part in the sort.
  assign alu_unused = ^{alu_y, alu_of, alu_zf};

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          r_d[0]  = x0;
          r_d[1]  = x1;
          r_d[2]  = x2;
          r_d[3]  = x3;
          state_d = S_C1;
        end
      end
      default: begin
        // Borrow set means r[i+1] < r[i]; equal values stay put (stable).
        if (alu_cf) begin
          r_d[idx_lo] = r_q[idx_hi];
          r_d[idx_hi] = r_q[idx_lo];
        end
        case (state_q)
          S_C1:    state_d = S_C2;
          S_C2:    state_d = S_C3;
          S_C3:    state_d = S_C4;
          S_C4:    state_d = S_C5;
          S_C5:    state_d = S_C6;
          default: state_d = S_DONE;
        endcase
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int unsigned i = 0; i < 4; i++) r_q[i] <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s0   = r_q[0];
  assign s1   = r_q[1];
  assign s2   = r_q[2];
  assign s3   = r_q[3];
  assign busy = busy_q;
  assign done = done_q;

endmodule
